// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the round-robin I/O bridge
package io_bridge_pkg;

  // Bridge sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2,
    WR_POST   = 2'd3
  } state_t;

  // Width of the address tag that selects the I/O window
  localparam int IO_TAG_W = 12;

endpackage

// File: rtl/io_bridge_rr_arbiter.sv
// rtl/io_bridge_rr_arbiter.sv - round-robin arbiter, first requester after the last grant wins
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  // Scan ports starting just after the pointer so the last winner is considered last
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = IW'(cand);
      end
    end
  end

  // Pointer remembers the last granted port; reset to N-1 so port 0 wins first
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= index;
    end
  end

endmodule

// File: rtl/io_bridge_rr.sv
// rtl/io_bridge_rr.sv - registered multi-port bridge onto a single I/O device master port
module io_bridge_rr
  import io_bridge_pkg::*;
#(
  parameter int                  NPORT   = 2,
  parameter int                  DW      = 32,
  parameter int                  AW      = 32,
  parameter logic [IO_TAG_W-1:0] IO_BASE = 12'hFD0,
  parameter int                  TMO     = 1023,
  parameter bit                  ACK_WR  = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NPORT-1:0]          s_cyc_i,
  input  logic [NPORT-1:0]          s_stb_i,
  input  logic [NPORT-1:0]          s_we_i,
  input  logic [NPORT*(DW/8)-1:0]   s_sel_i,
  input  logic [NPORT*AW-1:0]       s_adr_i,
  input  logic [NPORT*DW-1:0]       s_dat_i,
  output logic [NPORT-1:0]          s_ack_o,
  output logic [NPORT-1:0]          s_err_o,
  output logic [NPORT*DW-1:0]       s_dat_o,
  output logic                      m_cyc_o,
  output logic                      m_stb_o,
  output logic                      m_we_o,
  output logic [DW/8-1:0]           m_sel_o,
  output logic [AW-1:0]             m_adr_o,
  output logic [DW-1:0]             m_dat_o,
  input  logic                      m_ack_i,
  input  logic                      m_err_i,
  input  logic [DW-1:0]             m_dat_i
);

  localparam int SW = DW / 8;
  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t           state;
  logic [IW-1:0]    gidx;
  logic [31:0]      wdog;
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_we;
  logic             issue;
  logic             tmo_hit;
  logic             g_cyc;
  logic             g_stb;
  logic             m_open_n;
  logic             s_open_n;

  // A port requests only when its address tag falls inside the I/O window
  always_comb begin
    req = '0;
    for (int p = 0; p < NPORT; p++) begin
      req[p] = s_cyc_i[p] & s_stb_i[p] &
               (s_adr_i[p*AW + AW - IO_TAG_W +: IO_TAG_W] == IO_BASE);
    end
  end

  // A leftover device ack/err must clear before a new master cycle starts
  assign issue    = (state == IDLE) && !m_ack_i && !m_err_i && (|req);
  assign arb_we   = |(arb_gnt & s_we_i);
  assign tmo_hit  = (TMO != 0) && (wdog == 32'(TMO));
  assign g_cyc    = s_cyc_i[gidx];
  assign g_stb    = s_stb_i[gidx];
  // Posted-write bookkeeping: is each side still open after this edge
  assign m_open_n = m_cyc_o && !(m_ack_i || m_err_i || tmo_hit);
  assign s_open_n = s_ack_o[gidx] && g_stb && g_cyc;

  rr_arbiter #(.N(NPORT), .IW(IW)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .advance (issue),
    .grant   (arb_gnt),
    .index   (arb_idx)
  );

  // Bridge FSM: issue, wait for device, hold the response until the requester releases
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      gidx    <= '0;
      wdog    <= '0;
      s_ack_o <= '0;
      s_err_o <= '0;
      s_dat_o <= '0;
      {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            gidx    <= arb_idx;
            wdog    <= '0;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= arb_we;
            m_sel_o <= s_sel_i[arb_idx*SW +: SW];
            m_adr_o <= s_adr_i[arb_idx*AW +: AW];
            m_dat_o <= s_dat_i[arb_idx*DW +: DW];
            if (ACK_WR && arb_we) begin
              s_ack_o[arb_idx] <= 1'b1;
              state            <= WR_POST;
            end else begin
              state <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          if (m_ack_i) begin
            {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o} <= '0;
            s_ack_o[gidx]          <= 1'b1;
            s_dat_o[gidx*DW +: DW] <= m_dat_i;
            wdog                   <= '0;
            state                  <= WAIT_NACK;
          end else if (m_err_i || tmo_hit) begin
            {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o} <= '0;
            s_err_o[gidx] <= 1'b1;
            wdog          <= '0;
            state         <= WAIT_NACK;
          end else if (!g_cyc) begin
            {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o} <= '0;
            wdog  <= '0;
            state <= IDLE;
          end else if (wdog != '1) begin
            wdog <= wdog + 32'd1;
          end
        end
        WAIT_NACK: begin
          if (!g_stb || !g_cyc) begin
            s_ack_o <= '0;
            s_err_o <= '0;
            s_dat_o <= '0;
            wdog    <= '0;
            state   <= IDLE;
          end
        end
        WR_POST: begin
          if (m_cyc_o && !m_open_n) begin
            {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o} <= '0;
          end
          if (s_ack_o[gidx] && !s_open_n) begin
            s_ack_o[gidx] <= 1'b0;
          end
          if (!m_open_n && !s_open_n) begin
            wdog  <= '0;
            state <= IDLE;
          end else if (m_open_n && wdog != '1) begin
            wdog <= wdog + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bridge_rr.sv
// tb/tb_io_bridge_rr.sv - directed self-checking bench for io_bridge_rr
module tb_io_bridge_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  s_cyc, s_stb, s_we;
  logic [7:0]  s_sel;
  logic [63:0] s_adr, s_dat;
  logic        m_ack, m_err;
  logic [31:0] m_dat;

  logic [1:0]  a_ack, a_err, b_ack, b_err;
  logic [63:0] a_sdat, b_sdat;
  logic        a_mcyc, a_mstb, a_mwe, b_mcyc, b_mstb, b_mwe;
  logic [3:0]  a_msel, b_msel;
  logic [31:0] a_madr, a_mdat, b_madr, b_mdat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  io_bridge_rr #(.NPORT(2), .DW(32), .AW(32), .IO_BASE(12'hFD0), .TMO(16), .ACK_WR(1'b0)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_sel_i(s_sel),
    .s_adr_i(s_adr), .s_dat_i(s_dat),
    .s_ack_o(a_ack), .s_err_o(a_err), .s_dat_o(a_sdat),
    .m_cyc_o(a_mcyc), .m_stb_o(a_mstb), .m_we_o(a_mwe), .m_sel_o(a_msel),
    .m_adr_o(a_madr), .m_dat_o(a_mdat),
    .m_ack_i(m_ack), .m_err_i(m_err), .m_dat_i(m_dat)
  );

  io_bridge_rr #(.NPORT(2), .DW(32), .AW(32), .IO_BASE(12'hFD0), .TMO(16), .ACK_WR(1'b1)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_sel_i(s_sel),
    .s_adr_i(s_adr), .s_dat_i(s_dat),
    .s_ack_o(b_ack), .s_err_o(b_err), .s_dat_o(b_sdat),
    .m_cyc_o(b_mcyc), .m_stb_o(b_mstb), .m_we_o(b_mwe), .m_sel_o(b_msel),
    .m_adr_o(b_madr), .m_dat_o(b_mdat),
    .m_ack_i(m_ack), .m_err_i(m_err), .m_dat_i(m_dat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    s_cyc = '0; s_stb = '0; s_we = '0; s_sel = 8'hFF;
    s_adr = '0; s_dat = '0;
    m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_ack",  {30'd0, a_ack}, 32'd0);
    chk("rst_err",  {30'd0, a_err}, 32'd0);
    chk("rst_mcyc", {31'd0, a_mcyc}, 32'd0);
    chk("rst_sdat", a_sdat[31:0], 32'd0);
    chk("rst_mcyc_b", {31'd0, b_mcyc}, 32'd0);

    // 1: port 0 read, device acks three clocks after issue
    s_adr[31:0] = 32'hFD000010; s_cyc[0] = 1'b1; s_stb[0] = 1'b1;
    tick();
    chk("t1_mcyc", {31'd0, a_mcyc}, 32'd1);
    chk("t1_madr", a_madr, 32'hFD000010);
    chk("t1_mwe",  {31'd0, a_mwe}, 32'd0);
    chk("t1_noack", {30'd0, a_ack}, 32'd0);
    tick();
    tick();
    m_ack = 1'b1; m_dat = 32'hCAFEF00D;
    tick();
    chk("t1_ack",  {30'd0, a_ack}, 32'd1);
    chk("t1_sdat", a_sdat[31:0], 32'hCAFEF00D);
    chk("t1_mclr", {31'd0, a_mcyc}, 32'd0);
    m_ack = 1'b0; m_dat = '0;
    tick();
    chk("t1_hold", {30'd0, a_ack}, 32'd1);
    chk("t1_hdat", a_sdat[31:0], 32'hCAFEF00D);
    chk("t1_p1z",  a_sdat[63:32], 32'd0);
    s_cyc[0] = 1'b0; s_stb[0] = 1'b0;
    tick();
    chk("t1_rel",  {30'd0, a_ack}, 32'd0);
    chk("t1_relz", a_sdat[31:0], 32'd0);

    // 2: both ports contend, grants must alternate 0,1,0,1
    do_reset();
    s_adr = {32'hFD000020, 32'hFD000020};
    s_cyc = 2'b11; s_stb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = k % 2;
      tick();
      chk("t2_mcyc", {31'd0, a_mcyc}, 32'd1);
      m_ack = 1'b1; m_dat = 32'h000000A0 + k;
      tick();
      chk("t2_gnt",   {30'd0, a_ack}, 32'd1 << g);
      chk("t2_dat",   a_sdat[g*32 +: 32], 32'h000000A0 + k);
      chk("t2_other", a_sdat[(1-g)*32 +: 32], 32'd0);
      m_ack = 1'b0; m_dat = '0;
      s_cyc[g] = 1'b0; s_stb[g] = 1'b0;
      tick();
      chk("t2_rel", {30'd0, a_ack}, 32'd0);
      s_cyc[g] = 1'b1; s_stb[g] = 1'b1;
    end

    // 3: out-of-window address is never forwarded or answered
    do_reset();
    s_adr[31:0] = 32'h00001000; s_cyc[0] = 1'b1; s_stb[0] = 1'b1;
    tick(); tick(); tick();
    chk("t3_mcyc", {31'd0, a_mcyc}, 32'd0);
    chk("t3_ack",  {30'd0, a_ack}, 32'd0);
    chk("t3_err",  {30'd0, a_err}, 32'd0);

    // 4: watchdog at 16 cycles, error on the 18th clock after request
    do_reset();
    s_adr[31:0] = 32'hFD000030; s_cyc[0] = 1'b1; s_stb[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        chk("t4_pre_err",  {30'd0, a_err}, 32'd0);
        chk("t4_pre_mcyc", {31'd0, a_mcyc}, 32'd1);
      end
    end
    chk("t4_err",   {30'd0, a_err}, 32'd1);
    chk("t4_ack",   {30'd0, a_ack}, 32'd0);
    chk("t4_mcyc",  {31'd0, a_mcyc}, 32'd0);
    chk("t4_err_b", {30'd0, b_err}, 32'd1);
    s_cyc[0] = 1'b0; s_stb[0] = 1'b0;
    tick();
    chk("t4_rel", {30'd0, a_err}, 32'd0);

    // 5: posted write on port 1 (DUT b) versus non-posted (DUT a)
    do_reset();
    s_adr[63:32] = 32'hFD000004; s_dat[63:32] = 32'h12345678;
    s_we[1] = 1'b1; s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
    tick();
    chk("t5_bpack", {30'd0, b_ack}, 32'd2);
    chk("t5_bmcyc", {31'd0, b_mcyc}, 32'd1);
    chk("t5_bmwe",  {31'd0, b_mwe}, 32'd1);
    chk("t5_bmdat", b_mdat, 32'h12345678);
    chk("t5_bmadr", b_madr, 32'hFD000004);
    chk("t5_anack", {30'd0, a_ack}, 32'd0);
    chk("t5_amcyc", {31'd0, a_mcyc}, 32'd1);
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0; s_we[1] = 1'b0;
    tick();
    chk("t5_backdrop", {30'd0, b_ack}, 32'd0);
    chk("t5_bhold",    {31'd0, b_mcyc}, 32'd1);
    chk("t5_aabort",   {31'd0, a_mcyc}, 32'd0);
    tick();
    chk("t5_bhold2", {31'd0, b_mcyc}, 32'd1);
    m_ack = 1'b1;
    tick();
    chk("t5_bmclr", {31'd0, b_mcyc}, 32'd0);
    chk("t5_back0", {30'd0, b_ack}, 32'd0);
    chk("t5_aack0", {30'd0, a_ack}, 32'd0);
    m_ack = 1'b0;
    tick();

    // 6: abort, stale ack blocks the next issue, then device error path and reset mid-cycle
    do_reset();
    s_adr = {32'hFD000050, 32'hFD000040};
    s_cyc[0] = 1'b1; s_stb[0] = 1'b1;
    tick();
    chk("t6_issue", a_madr, 32'hFD000040);
    tick();
    s_cyc[0] = 1'b0; s_stb[0] = 1'b0;
    tick();
    chk("t6_abort", {31'd0, a_mcyc}, 32'd0);
    chk("t6_noack", {30'd0, a_ack}, 32'd0);
    m_ack = 1'b1;
    s_cyc[1] = 1'b1; s_stb[1] = 1'b1;
    tick();
    chk("t6_late",  {30'd0, a_ack}, 32'd0);
    chk("t6_block", {31'd0, a_mcyc}, 32'd0);
    tick();
    chk("t6_block2", {31'd0, a_mcyc}, 32'd0);
    m_ack = 1'b0;
    tick();
    chk("t6_go",   {31'd0, a_mcyc}, 32'd1);
    chk("t6_madr", a_madr, 32'hFD000050);
    m_err = 1'b1;
    tick();
    chk("t6_err",   {30'd0, a_err}, 32'd2);
    chk("t6_errna", {30'd0, a_ack}, 32'd0);
    chk("t6_emclr", {31'd0, a_mcyc}, 32'd0);
    m_err = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_rst_err", {30'd0, a_err}, 32'd0);
    rst = 1'b0;
    s_cyc = '0; s_stb = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
